// File: rtl/ucsbece154b_fetch_queue_pkg.sv
// rtl/ucsbece154b_fetch_queue_pkg.sv - shared widths, NOP encoding and entry type for the fetch queue
package ucsbece154b_fetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

    // Load-use stall freezes both slots; a slot-2 hazard lets only slot 1 go.
    function automatic logic [1:0] retire_request(input logic stall, input logic stall2);
        if (stall) return 2'd0;
        if (stall2) return 2'd1;
        return 2'd2;
    endfunction

endpackage

// File: rtl/ucsbece154b_fq_mem.sv
// rtl/ucsbece154b_fq_mem.sv - DEPTHx64 entry array, two write ports, two combinational read ports
module ucsbece154b_fq_mem
    import ucsbece154b_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we0,
    input  logic [AW-1:0]   waddr0,
    input  fq_entry_t       wdata0,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  fq_entry_t       wdata1,
    input  logic [AW-1:0]   raddr0,
    output fq_entry_t       rdata0,
    input  logic [AW-1:0]   raddr1,
    output fq_entry_t       rdata1
);

    fq_entry_t mem [DEPTH];

    // The two write addresses are tail and tail+1, so they never collide.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/ucsbece154b_fetch_queue.sv
// rtl/ucsbece154b_fetch_queue.sv - dual-issue instruction fetch queue feeding decode slots 1 and 2
module ucsbece154b_fetch_queue
    import ucsbece154b_fetch_queue_pkg::*;
#(
    parameter int              DEPTH = 8,
    parameter logic [XLEN-1:0] NOP   = NOP_INSTR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      FetchValid_i,
    input  logic                      FetchSingle_i,
    input  logic [XLEN-1:0]           FetchInstr0_i,
    input  logic [XLEN-1:0]           FetchInstr1_i,
    input  logic [XLEN-1:0]           FetchPC_i,
    output logic                      FetchReady_o,
    input  logic                      StallD_i,
    input  logic                      StallD2_i,
    input  logic                      FlushD_i,
    output logic [XLEN-1:0]           InstrD1_o,
    output logic [XLEN-1:0]           PCD1_o,
    output logic                      ValidD1_o,
    output logic [XLEN-1:0]           InstrD2_o,
    output logic [XLEN-1:0]           PCD2_o,
    output logic                      ValidD2_o,
    output logic [$clog2(DEPTH):0]    Count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [AW-1:0] head, tail, head_p1, tail_p1;
    logic [CW-1:0] count;
    logic          enq;
    logic [1:0]    enq_n, req_n, ret_n;
    logic          we0, we1;
    fq_entry_t     wdata0, wdata1, rdata0, rdata1;

    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);

    // Readiness looks only at the registered count so fetch never waits on decode timing.
    assign FetchReady_o = (count <= READY_MAX);

    always_comb begin
        enq   = FetchValid_i & FetchReady_o;
        enq_n = 2'd0;
        if (enq) enq_n = FetchSingle_i ? 2'd1 : 2'd2;
        req_n = retire_request(StallD_i, StallD2_i);
        ret_n = (count < CW'(req_n)) ? count[1:0] : req_n;
    end

    assign we0    = enq & ~FlushD_i;
    assign we1    = enq & ~FetchSingle_i & ~FlushD_i;
    assign wdata0 = '{instr: FetchInstr0_i, pc: FetchPC_i};
    assign wdata1 = '{instr: FetchInstr1_i, pc: FetchPC_i + 32'd4};

    ucsbece154b_fq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (tail),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (tail_p1),
        .wdata1 (wdata1),
        .raddr0 (head),
        .rdata0 (rdata0),
        .raddr1 (head_p1),
        .rdata1 (rdata1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (FlushD_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(ret_n);
            tail  <= tail + AW'(enq_n);
            count <= count + CW'(enq_n) - CW'(ret_n);
        end
    end

    assign ValidD1_o = (count != '0);
    assign ValidD2_o = (count >= CW'(2));
    assign InstrD1_o = ValidD1_o ? rdata0.instr : NOP;
    assign PCD1_o    = ValidD1_o ? rdata0.pc    : '0;
    assign InstrD2_o = ValidD2_o ? rdata1.instr : NOP;
    assign PCD2_o    = ValidD2_o ? rdata1.pc    : '0;
    assign Count_o   = count;

endmodule

// File: tb/tb_ucsbece154b_fetch_queue.sv
// tb/tb_ucsbece154b_fetch_queue.sv - directed self-checking bench for the fetch queue
module tb_ucsbece154b_fetch_queue;

    localparam logic [31:0] NOPW = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        FetchValid_i, FetchSingle_i;
    logic [31:0] FetchInstr0_i, FetchInstr1_i, FetchPC_i;
    logic        FetchReady_o;
    logic        StallD_i, StallD2_i, FlushD_i;
    logic [31:0] InstrD1_o, PCD1_o, InstrD2_o, PCD2_o;
    logic        ValidD1_o, ValidD2_o;
    logic [3:0]  Count_o;

    int total = 0;
    int bad   = 0;

    ucsbece154b_fetch_queue #(.DEPTH(8), .NOP(32'h00000013)) dut (
        .clk           (clk),
        .reset         (reset),
        .FetchValid_i  (FetchValid_i),
        .FetchSingle_i (FetchSingle_i),
        .FetchInstr0_i (FetchInstr0_i),
        .FetchInstr1_i (FetchInstr1_i),
        .FetchPC_i     (FetchPC_i),
        .FetchReady_o  (FetchReady_o),
        .StallD_i      (StallD_i),
        .StallD2_i     (StallD2_i),
        .FlushD_i      (FlushD_i),
        .InstrD1_o     (InstrD1_o),
        .PCD1_o        (PCD1_o),
        .ValidD1_o     (ValidD1_o),
        .InstrD2_o     (InstrD2_o),
        .PCD2_o        (PCD2_o),
        .ValidD2_o     (ValidD2_o),
        .Count_o       (Count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return pc ^ 32'hA5A50000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold();
        FetchValid_i = 1'b0; FetchSingle_i = 1'b0;
        StallD_i = 1'b1; StallD2_i = 1'b0; FlushD_i = 1'b0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic single);
        FetchValid_i = 1'b1; FetchSingle_i = single;
        FetchPC_i = pc; FetchInstr0_i = iw(pc); FetchInstr1_i = iw(pc + 32'd4);
    endtask

    task automatic test_reset();
        hold();
        reset = 1'b1;
        FetchPC_i = '0; FetchInstr0_i = '0; FetchInstr1_i = '0;
        step();
        total++; if (ValidD1_o !== 1'b0) begin bad++; $display("FAIL rst_v1 got=%b exp=0", ValidD1_o); end
        total++; if (ValidD2_o !== 1'b0) begin bad++; $display("FAIL rst_v2 got=%b exp=0", ValidD2_o); end
        total++; if (InstrD1_o !== NOPW) begin bad++; $display("FAIL rst_i1 got=%h exp=%h", InstrD1_o, NOPW); end
        total++; if (InstrD2_o !== NOPW) begin bad++; $display("FAIL rst_i2 got=%h exp=%h", InstrD2_o, NOPW); end
        total++; if (PCD1_o !== 32'd0 || PCD2_o !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h/%h exp=0/0", PCD1_o, PCD2_o); end
        total++; if (FetchReady_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", FetchReady_o); end
        total++; if (Count_o !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", Count_o); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_pair();
        FetchValid_i = 1'b1; FetchSingle_i = 1'b0; FetchPC_i = 32'h0;
        FetchInstr0_i = 32'h00500093; FetchInstr1_i = 32'h00600113;
        step();
        hold();
        total++; if (ValidD1_o !== 1'b1 || ValidD2_o !== 1'b1) begin bad++; $display("FAIL pair_valid got=%b%b exp=11", ValidD1_o, ValidD2_o); end
        total++; if (PCD1_o !== 32'h0 || PCD2_o !== 32'h4) begin bad++; $display("FAIL pair_pc got=%h/%h exp=0/4", PCD1_o, PCD2_o); end
        total++; if (InstrD1_o !== 32'h00500093 || InstrD2_o !== 32'h00600113) begin bad++; $display("FAIL pair_instr got=%h/%h exp=00500093/00600113", InstrD1_o, InstrD2_o); end
        total++; if (Count_o !== 4'd2) begin bad++; $display("FAIL pair_count got=%0d exp=2", Count_o); end
        FlushD_i = 1'b1;
        step();
        hold();
        total++; if (Count_o !== 4'd0) begin bad++; $display("FAIL pair_flush got=%0d exp=0", Count_o); end
    endtask

    task automatic test_stall_d2();
        offer(32'h0, 1'b0); step();
        offer(32'h8, 1'b0); step();
        hold(); StallD_i = 1'b0; StallD2_i = 1'b1;
        total++; if (Count_o !== 4'd4) begin bad++; $display("FAIL sd2_count0 got=%0d exp=4", Count_o); end
        step();
        total++; if (Count_o !== 4'd3) begin bad++; $display("FAIL sd2_count1 got=%0d exp=3", Count_o); end
        total++; if (PCD1_o !== 32'h4 || PCD2_o !== 32'h8) begin bad++; $display("FAIL sd2_pc1 got=%h/%h exp=4/8", PCD1_o, PCD2_o); end
        total++; if (InstrD1_o !== iw(32'h4)) begin bad++; $display("FAIL sd2_instr1 got=%h exp=%h", InstrD1_o, iw(32'h4)); end
        step();
        total++; if (Count_o !== 4'd2 || PCD1_o !== 32'h8 || PCD2_o !== 32'hC) begin bad++; $display("FAIL sd2_step2 got=%0d %h/%h exp=2 8/c", Count_o, PCD1_o, PCD2_o); end
        StallD2_i = 1'b0;
        step();
        hold();
        total++; if (Count_o !== 4'd0 || ValidD1_o !== 1'b0 || InstrD1_o !== NOPW) begin bad++; $display("FAIL sd2_drain got=%0d %b %h exp=0 0 %h", Count_o, ValidD1_o, InstrD1_o, NOPW); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] pcs [4];
        pcs[0] = 32'h100; pcs[1] = 32'h108; pcs[2] = 32'h110; pcs[3] = 32'h118;
        for (int i = 0; i < 4; i++) begin
            offer(pcs[i], 1'b0);
            step();
        end
        total++; if (Count_o !== 4'd8 || FetchReady_o !== 1'b0) begin bad++; $display("FAIL full_state got=%0d rdy=%b exp=8 rdy=0", Count_o, FetchReady_o); end
        offer(32'h200, 1'b0);
        step();
        total++; if (Count_o !== 4'd8) begin bad++; $display("FAIL full_blocked got=%0d exp=8", Count_o); end
        hold(); StallD_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (PCD1_o !== pcs[i] || PCD2_o !== pcs[i] + 32'd4 || InstrD2_o !== iw(pcs[i] + 32'd4) || Count_o !== 4'(8 - 2*i)) begin
                bad++;
                $display("FAIL wrap_%0d got=%h/%h %h cnt=%0d exp=%h/%h %h cnt=%0d", i, PCD1_o, PCD2_o, InstrD2_o, Count_o, pcs[i], pcs[i] + 32'd4, iw(pcs[i] + 32'd4), 8 - 2*i);
            end
            step();
        end
        hold();
        total++; if (Count_o !== 4'd0 || FetchReady_o !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%0d rdy=%b exp=0 rdy=1", Count_o, FetchReady_o); end
    endtask

    task automatic test_single();
        offer(32'h10, 1'b1); step();
        hold();
        total++; if (Count_o !== 4'd1 || ValidD2_o !== 1'b0 || InstrD2_o !== NOPW || PCD2_o !== 32'd0) begin bad++; $display("FAIL single_one got=%0d %b %h %h exp=1 0 %h 0", Count_o, ValidD2_o, InstrD2_o, PCD2_o, NOPW); end
        offer(32'h40, 1'b0); step();
        hold();
        total++; if (Count_o !== 4'd3 || PCD1_o !== 32'h10 || PCD2_o !== 32'h40 || InstrD2_o !== iw(32'h40)) begin bad++; $display("FAIL single_follow got=%0d %h/%h %h exp=3 10/40 %h", Count_o, PCD1_o, PCD2_o, InstrD2_o, iw(32'h40)); end
        offer(32'h50, 1'b0); step();
        offer(32'h58, 1'b0); step();
        hold();
        total++; if (Count_o !== 4'd7 || FetchReady_o !== 1'b0) begin bad++; $display("FAIL seven_ready got=%0d rdy=%b exp=7 rdy=0", Count_o, FetchReady_o); end
        StallD_i = 1'b0; StallD2_i = 1'b1;
        step();
        total++; if (Count_o !== 4'd6 || FetchReady_o !== 1'b1 || PCD1_o !== 32'h40) begin bad++; $display("FAIL six_state got=%0d rdy=%b %h exp=6 rdy=1 40", Count_o, FetchReady_o, PCD1_o); end
        offer(32'h60, 1'b0); StallD_i = 1'b0; StallD2_i = 1'b0;
        step();
        hold();
        total++; if (Count_o !== 4'd6 || PCD1_o !== 32'h50 || PCD2_o !== 32'h54) begin bad++; $display("FAIL enq_deq got=%0d %h/%h exp=6 50/54", Count_o, PCD1_o, PCD2_o); end
    endtask

    task automatic test_flush();
        StallD_i = 1'b0; StallD2_i = 1'b1;
        step();
        hold();
        total++; if (Count_o !== 4'd5 || PCD1_o !== 32'h54) begin bad++; $display("FAIL flush_pre got=%0d %h exp=5 54", Count_o, PCD1_o); end
        offer(32'h300, 1'b0); StallD_i = 1'b0; FlushD_i = 1'b1;
        step();
        hold();
        total++; if (Count_o !== 4'd0 || ValidD1_o !== 1'b0 || ValidD2_o !== 1'b0 || InstrD1_o !== NOPW || PCD1_o !== 32'd0) begin bad++; $display("FAIL flush_state got=%0d %b%b %h %h exp=0 00 %h 0", Count_o, ValidD1_o, ValidD2_o, InstrD1_o, PCD1_o, NOPW); end
        step();
        total++; if (Count_o !== 4'd0) begin bad++; $display("FAIL flush_discard got=%0d exp=0", Count_o); end
        offer(32'h400, 1'b0); step();
        hold();
        total++; if (PCD1_o !== 32'h400 || Count_o !== 4'd2) begin bad++; $display("FAIL flush_after got=%h cnt=%0d exp=400 cnt=2", PCD1_o, Count_o); end
    endtask

    task automatic test_async_reset();
        offer(32'h408, 1'b0); step();
        offer(32'h410, 1'b0); step();
        hold();
        total++; if (Count_o !== 4'd6) begin bad++; $display("FAIL areset_pre got=%0d exp=6", Count_o); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (Count_o !== 4'd0 || ValidD1_o !== 1'b0 || InstrD1_o !== NOPW || FetchReady_o !== 1'b1) begin bad++; $display("FAIL areset_now got=%0d %b %h rdy=%b exp=0 0 %h rdy=1", Count_o, ValidD1_o, InstrD1_o, FetchReady_o, NOPW); end
        step();
        reset = 1'b0;
        offer(32'h500, 1'b0); step();
        hold();
        total++; if (PCD1_o !== 32'h500 || InstrD1_o !== iw(32'h500) || Count_o !== 4'd2) begin bad++; $display("FAIL areset_after got=%h %h cnt=%0d exp=500 %h cnt=2", PCD1_o, InstrD1_o, Count_o, iw(32'h500)); end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_stall_d2();
        test_full_wrap();
        test_single();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_fetch_queue.md
# ucsbece154b_fetch_queue

Instruction fetch queue that feeds the dual-issue decode stage. It accepts up to two instructions per cycle from instruction memory, stores them with their PCs in a circular buffer, and presents the two oldest entries to decode slots 1 and 2. Each cycle it retires 0, 1 or 2 entries according to the controller's stall outputs. When slot 2 is held by a hazard, its instruction moves to slot 1 on the next cycle. The queue is cleared on a mispredict.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- NOP, 32'h00000013, instruction word driven on an invalid slot.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- FetchValid_i  in  1  a fetch pair is offered this cycle.
- FetchSingle_i  in  1  only instr0 of the pair is valid (predicted-taken branch in slot 0, or 8-byte misaligned PC).
- FetchInstr0_i  in  32  instruction at FetchPC_i.
- FetchInstr1_i  in  32  instruction at FetchPC_i+4.
- FetchPC_i  in  32  PC of instr0.
- FetchReady_o  out  1  queue can accept a full pair this cycle.
- StallD_i  in  1  slot-1 stall from the controller (load-use); retire nothing.
- StallD2_i  in  1  slot-2 hazard from the controller; retire only slot 1.
- FlushD_i  in  1  mispredict; empty the queue.
- InstrD1_o  out  32  oldest entry, or NOP when invalid.
- PCD1_o  out  32  PC of the oldest entry, or 0 when invalid.
- ValidD1_o  out  1  oldest entry is valid.
- InstrD2_o  out  32  second-oldest entry, or NOP when invalid.
- PCD2_o  out  32  PC of the second-oldest entry, or 0 when invalid.
- ValidD2_o  out  1  second-oldest entry is valid.
- Count_o  out  log2(DEPTH)+1  current occupancy.

## Operation
- State: entry array (instr + PC) of DEPTH entries; head and tail pointers of log2(DEPTH) bits each; count of log2(DEPTH)+1 bits.
- Pointers wrap modulo DEPTH. Index head+1 also wraps.
- Enqueue happens when FetchValid_i & FetchReady_o.
  - Write instr0/PC at tail.
  - Unless FetchSingle_i, write instr1/PC+4 at tail+1.
  - tail advances by 1 or 2.
- FetchReady_o = (count <= DEPTH-2). It is computed from registered count only and never depends on same-cycle dequeue.
- Requested retire count: 0 if StallD_i, else 1 if StallD2_i, else 2. StallD_i has priority.
- Actual retire count = min(requested, count). head advances by the actual retire count.
- Next count = count + enqueued − retired. Overflow is impossible by construction.
- ValidD1_o = (count >= 1). ValidD2_o = (count >= 2).
- Slot outputs read the array combinationally at head and head+1. An invalid slot forces NOP and PC 0.
- FlushD_i: the next edge sets head = tail = 0 and count = 0. Flush overrides any same-cycle enqueue and dequeue; the offered pair is discarded.
- There is no bypass: an instruction enqueued at edge N is first visible at the outputs after edge N.

## Timing
- Reset (asynchronous): head = tail = 0, count = 0.
  - ValidD1_o = ValidD2_o = 0, InstrD1_o = InstrD2_o = NOP, PCD1_o = PCD2_o = 0.
  - FetchReady_o = 1, Count_o = 0.
  - Array contents are don't-care.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Enqueue-to-output latency: 1 cycle.
- Held slot 2 (StallD2_i): the entry at head+1 becomes slot 1 on the next cycle, and a newly fetched or stored entry fills slot 2.
- Simultaneous enqueue and retire at count = DEPTH-2: legal; count ends at DEPTH-2 + 2 − retired.
- Full (count ≥ DEPTH-1): FetchReady_o = 0, and the fetch stage must hold its PC.
- Empty (count = 0) with retire requested: no pointer change, outputs stay NOP/invalid.

## Structure
- NOP encoding and XLEN (32) belong in ucsbece154b_defines.vh, next to the existing opcode constants.
- One sub-module, ucsbece154b_fq_mem: DEPTH×64 register array with two write ports (tail, tail+1) and two combinational read ports (head, head+1). It has no reset.
- Pointer, count and valid logic stay in the top module.

## Test plan
- Reset, then fetch pair {0x00500093, 0x00600113} at PC 0x0 -> next cycle ValidD1=ValidD2=1, PCD1=0x0, PCD2=0x4, Count=2.
- Hold StallD2_i=1 for one cycle after fetching pairs at 0x0 and 0x8 -> slot 1 shows PC 0x4 and slot 2 shows PC 0x8, Count decrements by 1 per held cycle.
- Fetch continuously with StallD_i=1 and DEPTH=8 -> FetchReady_o drops when Count=7 (after a single fetch) or 8; no entry is overwritten; after release, PCs come out in order across the pointer wrap.
- FetchSingle_i=1 at PC 0x10 -> exactly one entry is added (Count +1), and the next pair at 0x40 follows 0x10 in slot 2.
- FlushD_i=1 together with a valid fetch at Count=5 -> next cycle Count=0, both slots invalid with NOP, and the offered pair is not stored.
- Assert reset between clock edges with Count=6 -> outputs go to reset values immediately, and the first fetch after deassertion appears at slot 1.
